// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Purpose: shared constants for the handshaked EX-stage ALU.
//   - 4-bit opcodes. The 3-bit codes of the older 16-bit ALU are kept
//     unchanged and zero-extended.
//   - State encoding for the sequencer in alu_seq.
// Ports: none (package).
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_NOR  = 4'b0100;
    localparam logic [3:0] OP_SLL  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLTU = 4'b0111;
    localparam logic [3:0] OP_SLT  = 4'b1000;
    localparam logic [3:0] OP_SRL  = 4'b1001;
    localparam logic [3:0] OP_SRA  = 4'b1010;
    localparam logic [3:0] OP_MUL  = 4'b1011;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/alu_seq_if.sv
// ---------------------------------------------------------------------------
// alu_seq_if
// Purpose: bundles the operand-side and result-side handshakes of alu_seq.
// Signals:
//   in_valid/in_ready      operand handshake
//   input1, input2         operands (input2 also carries the shift amount)
//   ALUControl             4-bit opcode
//   out_valid/out_ready    result handshake
//   result, zero, carry, overflow, err   result and status flags
// Modports:
//   master  the producer/consumer driving operations into the ALU
//   slave   the ALU itself
// ---------------------------------------------------------------------------
interface alu_seq_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] input1;
    logic [WIDTH-1:0] input2;
    logic [3:0]       ALUControl;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             carry;
    logic             overflow;
    logic             err;

    modport master (
        output in_valid, input1, input2, ALUControl, out_ready,
        input  in_ready, out_valid, result, zero, carry, overflow, err
    );

    modport slave (
        input  in_valid, input1, input2, ALUControl, out_ready,
        output in_ready, out_valid, result, zero, carry, overflow, err
    );
endinterface

// File: rtl/alu_mul_seq.sv
// ---------------------------------------------------------------------------
// alu_mul_seq
// Purpose: radix-2 shift-add multiplier returning the low WIDTH bits of the
//          unsigned product. Takes exactly WIDTH iteration cycles.
// Ports:
//   clock    rising-edge clock
//   reset_n  synchronous active-low reset; aborts any multiply in flight
//   start    load a/b and begin (ignored while busy)
//   a, b     multiplicand, multiplier
//   busy     iterations in progress
//   done     high during the final iteration cycle; product is valid then
//   product  accumulator value including the final iteration's add
// ---------------------------------------------------------------------------
module alu_mul_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product
);
    localparam int CNT_W = $clog2(WIDTH);

    logic [WIDTH-1:0] mcand_reg;
    logic [WIDTH-1:0] mplier_reg;
    logic [WIDTH-1:0] acc_reg;
    logic [WIDTH-1:0] acc_next;
    logic [CNT_W-1:0] cnt_reg;
    logic             busy_reg;

    // Partial products above bit WIDTH-1 are shifted out of mcand_reg,
    // which is exactly the modulo-2^WIDTH truncation wanted.
    assign acc_next = acc_reg + (mplier_reg[0] ? mcand_reg : '0);
    assign done     = busy_reg && (cnt_reg == CNT_W'(WIDTH - 1));
    assign product  = acc_next;
    assign busy     = busy_reg;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            busy_reg   <= 1'b0;
            cnt_reg    <= '0;
            acc_reg    <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
        end else if (start && !busy_reg) begin
            busy_reg   <= 1'b1;
            cnt_reg    <= '0;
            acc_reg    <= '0;
            mcand_reg  <= a;
            mplier_reg <= b;
        end else if (busy_reg) begin
            acc_reg    <= acc_next;
            mcand_reg  <= mcand_reg << 1;
            mplier_reg <= mplier_reg >> 1;
            cnt_reg    <= cnt_reg + 1'b1;
            if (done) begin
                busy_reg <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq
// Purpose: handshaked EX-stage ALU. Single-cycle logic/arith/shift/compare
//          ops plus a WIDTH-cycle shift-add multiply. Each result is held
//          under backpressure until the consumer takes it.
// Ports:
//   clock    rising-edge clock
//   reset_n  synchronous active-low reset (overrides everything)
//   bus      alu_seq_if.slave: in_valid/in_ready, input1, input2,
//            ALUControl, out_valid/out_ready, result, zero, carry,
//            overflow, err
// ---------------------------------------------------------------------------
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic       clock,
    input  logic       reset_n,
    alu_seq_if.slave   bus
);
    logic [1:0]       state_reg;
    logic [WIDTH-1:0] result_reg;
    logic             zero_reg;
    logic             carry_reg;
    logic             overflow_reg;
    logic             err_reg;

    logic             accept;
    logic             mul_start;
    logic             mul_busy;
    logic             mul_done;
    logic [WIDTH-1:0] mul_product;

    logic [WIDTH-1:0] alu_res;
    logic             alu_carry;
    logic             alu_ovf;
    logic             alu_err;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] diff;
    logic [SHAMT_W-1:0] shamt;

    // in_ready is also gated by reset_n so it reads 0 during every reset cycle.
    assign bus.in_ready  = (state_reg == ST_IDLE) && reset_n;
    assign bus.out_valid = (state_reg == ST_DONE);
    assign bus.result    = result_reg;
    assign bus.zero      = zero_reg;
    assign bus.carry     = carry_reg;
    assign bus.overflow  = overflow_reg;
    assign bus.err       = err_reg;

    assign accept    = bus.in_valid && bus.in_ready;
    assign mul_start = accept && (bus.ALUControl == OP_MUL);

    assign sum   = {1'b0, bus.input1} + {1'b0, bus.input2};
    assign diff  = bus.input1 - bus.input2;
    assign shamt = bus.input2[SHAMT_W-1:0];

    // Single-cycle datapath, evaluated on the operands presented at accept.
    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        alu_err   = 1'b0;
        case (bus.ALUControl)
            OP_AND:  alu_res = bus.input1 & bus.input2;
            OP_OR:   alu_res = bus.input1 | bus.input2;
            OP_XOR:  alu_res = bus.input1 ^ bus.input2;
            OP_NOR:  alu_res = ~(bus.input1 | bus.input2);
            OP_ADD: begin
                alu_res   = sum[WIDTH-1:0];
                alu_carry = sum[WIDTH];
                alu_ovf   = (bus.input1[WIDTH-1] == bus.input2[WIDTH-1]) &&
                            (sum[WIDTH-1] != bus.input1[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res   = diff;
                alu_carry = (bus.input1 < bus.input2);
                alu_ovf   = (bus.input1[WIDTH-1] != bus.input2[WIDTH-1]) &&
                            (diff[WIDTH-1] != bus.input1[WIDTH-1]);
            end
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (bus.input1 < bus.input2)};
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}},
                                ($signed(bus.input1) < $signed(bus.input2))};
            OP_SLL:  alu_res = bus.input1 << shamt;
            OP_SRL:  alu_res = bus.input1 >> shamt;
            OP_SRA:  alu_res = $unsigned($signed(bus.input1) >>> shamt);
            OP_MUL:  alu_res = '0;      // produced by alu_mul_seq
            default: alu_err = 1'b1;
        endcase
    end

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (mul_start),
        .a       (bus.input1),
        .b       (bus.input2),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_reg    <= ST_IDLE;
            result_reg   <= '0;
            zero_reg     <= 1'b0;
            carry_reg    <= 1'b0;
            overflow_reg <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        if (bus.ALUControl == OP_MUL) begin
                            state_reg <= ST_MUL;
                        end else begin
                            result_reg   <= alu_res;
                            zero_reg     <= (alu_res == '0);
                            carry_reg    <= alu_carry;
                            overflow_reg <= alu_ovf;
                            err_reg      <= alu_err;
                            state_reg    <= ST_DONE;
                        end
                    end
                end
                ST_MUL: begin
                    if (mul_done) begin
                        result_reg   <= mul_product;
                        zero_reg     <= (mul_product == '0);
                        carry_reg    <= 1'b0;
                        overflow_reg <= 1'b0;
                        err_reg      <= 1'b0;
                        state_reg    <= ST_DONE;
                    end else if (!mul_busy) begin
                        // Multiplier idle without finishing: never expected,
                        // recover rather than hang.
                        state_reg <= ST_IDLE;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end
endmodule
